// File: rtl/push_button_debouncer.sv
// Push-button debouncer: two-flop synchronizer feeding a stability-check FSM that
// produces a clean level for the one-pulser plus registered press/release strobes.
module push_button_debouncer #(
  parameter  int unsigned DEBOUNCE_CYCLES = 16,
  localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic pbRaw,
  output logic pbOut,
  output logic pressPulse,
  output logic releasePulse
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] PRESS_CHK   = 2'd1;
  localparam logic [1:0] HELD        = 2'd2;
  localparam logic [1:0] RELEASE_CHK = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_d, s1_q;
  logic             s2_d, s2_q;
  logic [1:0]       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             pb_out_d, pb_out_q;
  logic             press_d, press_q;
  logic             release_d, release_q;
  logic             pb_sync;

  assign pb_sync = s2_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    s1_d      = pbRaw;
    s2_d      = s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pb_sync) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (!pb_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pb_sync) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (pb_sync) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Level follows the accepted state, so bounce inside the check states never reaches it.
    pb_out_d = (state_d == HELD) || (state_d == RELEASE_CHK);
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      pb_out_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pb_out_q  <= pb_out_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign pbOut        = pb_out_q;
  assign pressPulse   = press_q;
  assign releasePulse = release_q;

endmodule

// File: tb/tb_push_button_debouncer.sv
// Self-checking bench for push_button_debouncer: directed tables and sequences plus
// randomized bounce stimulus compared against a run-length reference model.
module tb_push_button_debouncer;

  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic pbRaw = 1'b0;
  logic pbOut, pressPulse, releasePulse;

  int n_chk = 0;
  int n_err = 0;

  push_button_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .pbRaw        (pbRaw),
    .pbOut        (pbOut),
    .pressPulse   (pressPulse),
    .releasePulse (releasePulse)
  );

  always #5 clk = ~clk;

  // Downstream one-pulser: one-cycle enable on each rising edge of its clkPB input.
  logic pb_prev;
  logic clk_en;
  always @(posedge clk or negedge rst) begin
    if (!rst) pb_prev <= 1'b0;
    else      pb_prev <= pbOut;
  end
  assign clk_en = pbOut & ~pb_prev;

  // Reference model: a level flips once DC+1 consecutive synchronized samples disagree with it.
  logic hist[$];
  logic m_lvl;
  int   m_run;
  logic m_press, m_rel;

  task automatic model_reset();
    hist.delete();
    m_lvl   = 1'b0;
    m_run   = 0;
    m_press = 1'b0;
    m_rel   = 1'b0;
  endtask

  task automatic model_step(input logic raw);
    logic sync;
    hist.push_front(raw);
    if (hist.size() > 3) void'(hist.pop_back());
    sync    = (hist.size() == 3) ? hist[2] : 1'b0;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (sync == m_lvl) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DC + 1) begin
        m_lvl = sync;
        m_run = 0;
        if (sync) m_press = 1'b1;
        else      m_rel   = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_out, input logic e_press, input logic e_rel);
    check({tag, ".pbOut"},        pbOut,        e_out);
    check({tag, ".pressPulse"},   pressPulse,   e_press);
    check({tag, ".releasePulse"}, releasePulse, e_rel);
  endtask

  // Drive pbRaw ahead of the next rising edge, then return at the following falling edge.
  task automatic cycle(input logic raw);
    pbRaw = raw;
    @(posedge clk);
    model_step(raw);
    @(negedge clk);
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 rst = 1'b0;
    #1 check_outs(tag, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic raw;
    logic out;
    logic press;
    logic rel;
  } vec_t;

  vec_t tbl[24];
  logic glitch[14] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  logic bounce[16] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_en, n_pr, n_rl, n_wide, run_left;
    logic en_prev, lvl;

    // Clean press before edge 6 and release before edge 16, counted from the first table edge.
    for (int i = 0; i < 24; i++) begin
      tbl[i].raw   = (i >= 6) && (i < 16);
      tbl[i].out   = (i >= 6 + LAT) && (i < 16 + LAT);
      tbl[i].press = (i == 6 + LAT);
      tbl[i].rel   = (i == 16 + LAT);
    end

    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cycle(1'b0);
      check_outs($sformatf("idle[%0d]", i), 1'b0, 1'b0, 1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      cycle(tbl[i].raw);
      check_outs($sformatf("table[%0d]", i), tbl[i].out, tbl[i].press, tbl[i].rel);
    end

    repeat (8) cycle(1'b1);
    check("held_before_glitch.pbOut", pbOut, 1'b1);
    for (int i = 0; i < 14; i++) begin
      cycle(glitch[i]);
      check_outs($sformatf("rel_glitch[%0d]", i), (i < 11), 1'b0, (i == 11));
    end

    repeat (3) cycle(1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(bounce[i]);
      check_outs($sformatf("bounce[%0d]", i), (i >= 5 + LAT), (i == 5 + LAT), 1'b0);
    end
    repeat (10) cycle(1'b0);
    check("after_bounce_release.pbOut", pbOut, 1'b0);

    repeat (4) cycle(1'b1);
    async_reset_pulse("rst_mid_press");
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1);
      check_outs($sformatf("requal_a[%0d]", i), (i >= LAT), (i == LAT), 1'b0);
    end

    async_reset_pulse("rst_in_held");
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1);
      check_outs($sformatf("requal_b[%0d]", i), (i >= LAT), (i == LAT), 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      cycle(1'b0);
      check_outs($sformatf("rel_chk[%0d]", i), 1'b1, 1'b0, 1'b0);
    end
    async_reset_pulse("rst_mid_release");
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0);
      check_outs($sformatf("post_rst_idle[%0d]", i), 1'b0, 1'b0, 1'b0);
    end

    n_en = 0; n_pr = 0; n_rl = 0; n_wide = 0; en_prev = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 100; i++) begin
        cycle(i < 50);
        if (clk_en) n_en++;
        if (clk_en && en_prev) n_wide++;
        en_prev = clk_en;
        if (pressPulse)   n_pr++;
        if (releasePulse) n_rl++;
      end
    end
    check_int("onepulse.clk_en_count",    n_en,   3);
    check_int("onepulse.clk_en_wide",     n_wide, 0);
    check_int("onepulse.press_count",     n_pr,   3);
    check_int("onepulse.release_count",   n_rl,   3);

    run_left = 0;
    lvl      = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (run_left == 0) begin
        lvl      = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      cycle(lvl);
      check_outs($sformatf("rand[%0d]", n), m_lvl, m_press, m_rel);
      if ($urandom_range(0, 299) == 0) async_reset_pulse($sformatf("rand_rst[%0d]", n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/push_button_debouncer.md
Name: push_button_debouncer

Overview:
- Sits directly upstream of the one-pulse generator.
- Takes the raw, asynchronous, bouncing push-button input and synchronizes it to clk, then filters out bounce. Delivers a clean level (pbOut) for the one-pulser's clkPB input.
- Also provides registered single-cycle press and release strobes for blocks that want edge events without a separate pulser.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronized-stable cycles required to accept a level change. Legal range 2..65535; the lab build uses 250000/16-scaled values per board clock.
- CNT_W, $clog2(DEBOUNCE_CYCLES), width of the stability counter. Derived; not overridden.

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, asynchronous active-low reset: 0 resets, 1 runs.
- pbRaw, input, 1, raw push-button level; asynchronous to clk, active-high, may bounce.
- pbOut, output, 1, debounced level; connects to the one-pulser's clkPB.
- pressPulse, output, 1, one-cycle strobe on accepted press.
- releasePulse, output, 1, one-cycle strobe on accepted release.

Behaviour:
- Reset (rst=0, asynchronous, effective immediately, any state):
  - both synchronizer flops = 0, state = IDLE, counter = 0.
  - pbOut = 0, pressPulse = 0, releasePulse = 0.
- Synchronizer:
  - Two flops, s1 <= pbRaw, s2 <= s1.
  - pbSync = s2. The FSM never samples pbRaw directly.
- FSM states: IDLE, PRESS_CHK, HELD, RELEASE_CHK.
- IDLE:
  - pbSync=1 -> PRESS_CHK, cnt <= 0.
  - Otherwise stay.
- PRESS_CHK:
  - pbSync=0 -> IDLE, cnt <= 0 (bounce rejected, no strobe).
  - pbSync=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, pressPulse <= 1 for exactly one cycle.
  - pbSync=1 otherwise -> cnt <= cnt+1.
- HELD:
  - pbSync=0 -> RELEASE_CHK, cnt <= 0.
  - Otherwise stay.
- RELEASE_CHK:
  - pbSync=1 -> HELD, cnt <= 0 (release bounce rejected, no strobe).
  - pbSync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, releasePulse <= 1 for exactly one cycle.
  - pbSync=0 otherwise -> cnt <= cnt+1.
- Outputs:
  - pbOut is registered and equals 1 in HELD and RELEASE_CHK, 0 in IDLE and PRESS_CHK. It never glitches during bounce.
  - pressPulse and releasePulse are registered. They are never high in the same cycle and never high for 2 consecutive cycles.
- Latency, press: pbRaw rises with setup before edge k -> pbSync=1 after edge k+1 -> PRESS_CHK after edge k+2 -> HELD (pbOut=1, pressPulse=1) after edge k+2+DEBOUNCE_CYCLES.
- Latency, release: symmetric, same latency to pbOut=0 and releasePulse=1.
- Counter:
  - Saturating by construction: never exceeds DEBOUNCE_CYCLES-1.
  - Cleared on every state transition. Never wraps.
- Glitches shorter than DEBOUNCE_CYCLES synchronized cycles produce no change on any output.
- pbRaw held high indefinitely: remain in HELD, pressPulse fires once only.
- Reset mid-PRESS_CHK or mid-RELEASE_CHK: no strobe emitted. After rst deasserts with pbRaw=1, a full press qualification (latency above) is required before pbOut=1.

Test Plan:
1. DEBOUNCE_CYCLES=4, rst=0 then 1, pbRaw=0 for 20 cycles -> pbOut, pressPulse, releasePulse stay 0.
2. DEBOUNCE_CYCLES=4, clean press: pbRaw 0->1 before edge 10, held -> pbOut=1 and pressPulse=1 after edge 16. pressPulse=0 after edge 17. pbOut stays 1.
3. DEBOUNCE_CYCLES=4, bounce: pbRaw pattern 1,0,1,1,0,1 (one cycle each), then steady 1 -> no output activity during bounce. pbOut=1 exactly 6 cycles after the final steady rise reaches pbRaw. Exactly one pressPulse.
4. DEBOUNCE_CYCLES=4, release after case 2: pbRaw 1->0 before edge 30 -> pbOut=0 and releasePulse=1 after edge 36. A 2-cycle high glitch during RELEASE_CHK restarts the check with no releasePulse.
5. DEBOUNCE_CYCLES=4, rst pulled to 0 while in PRESS_CHK -> all outputs 0 immediately (asynchronous, without a clock edge). After release with pbRaw=1, pbOut=1 only 6 cycles after the first edge with rst=1.
6. Integration with the one-pulser: 3 separate clean presses, each held 50 cycles -> exactly 3 single-cycle clkEn pulses and 3 pressPulse strobes.
